addend_gatherer: RTL and testbench

- Serial-to-parallel front end for the adder reduction tree.
- Accepts one WORD_WIDTH operand per cycle over a valid/ready stream and packs ADDENDS operands into one flat vector.
- Presents the vector on a valid/ready output whose data port is wired directly to the reducer's addends input.
- Supports early termination: short operand groups are zero-padded, so the reduction tree sums only the supplied words.

---
 rtl/addend_gatherer.sv | 87 ++++++++
 tb/tb_addend_gatherer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/addend_gatherer.sv
// Serial-to-parallel front end for the adder reduction tree.
// Packs up to ADDENDS operand words into one flat vector; short groups are zero-padded.
module addend_gatherer #(
  parameter int unsigned WORD_WIDTH  = 36,
  parameter int unsigned ADDENDS     = 8,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WORD_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [ADDENDS*WORD_WIDTH-1:0] addends,
  output logic                          addends_valid,
  input  logic                          addends_ready,
  output logic [COUNT_WIDTH-1:0]        fill_count
);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e                        state_q, state_d;
  logic [ADDENDS*WORD_WIDTH-1:0] addends_q, addends_d;
  logic [COUNT_WIDTH-1:0]        count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  // in_ready never looks at in_valid, so no combinational loop through the handshake.
  assign in_ready = (state_q == StFill) ? 1'b1 : addends_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = (state_q == StFull) && addends_ready;

  always_comb begin
    state_d   = state_q;
    addends_d = addends_q;
    count_d   = count_q;
    unique case (state_q)
      StFill: begin
        if (in_xfer) begin
          for (int unsigned i = 0; i < ADDENDS; i++) begin
            if (count_q == COUNT_WIDTH'(i)) begin
              addends_d[i*WORD_WIDTH +: WORD_WIDTH] = in_data;
            end
          end
          count_d = count_q + COUNT_WIDTH'(1);
          if (count_q == COUNT_WIDTH'(ADDENDS - 1) || in_last) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (out_xfer) begin
          addends_d = '0;
          count_d   = '0;
          state_d   = StFill;
          // A word arriving with the handoff starts the next vector with no bubble.
          if (in_xfer) begin
            addends_d[0 +: WORD_WIDTH] = in_data;
            count_d                    = COUNT_WIDTH'(1);
            if (in_last || ADDENDS == 1) begin
              state_d = StFull;
            end
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StFill;
      addends_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addends_q <= addends_d;
      count_q   <= count_d;
    end
  end

  assign addends       = addends_q;
  assign addends_valid = (state_q == StFull);
  assign fill_count    = count_q;

endmodule

// File: tb/tb_addend_gatherer.sv
// Directed, table-driven bench for addend_gatherer with hand-computed expectations.
module tb_addend_gatherer;

  localparam int W  = 36;
  localparam int N  = 8;
  localparam int CW = 4;
  localparam logic [W-1:0] MaxWord = {W{1'b1}};

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic [N*W-1:0]  addends;
  logic            addends_valid;
  logic            addends_ready = 1'b1;
  logic [CW-1:0]   fill_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           n;
    logic [W-1:0] w [N];
    logic [39:0]  sum;
  } vec_t;

  vec_t vecs [5];

  always #5 clock = ~clock;

  addend_gatherer #(
    .WORD_WIDTH (W),
    .ADDENDS    (N),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .addends      (addends),
    .addends_valid(addends_valid),
    .addends_ready(addends_ready),
    .fill_count   (fill_count)
  );

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] vsum(input logic [N*W-1:0] v);
    logic [39:0] s = '0;
    for (int i = 0; i < N; i++) s += 40'(v[i*W +: W]);
    return s;
  endfunction

  // Present one word and hold it until the gatherer accepts it (bounded wait).
  task automatic send(input logic [W-1:0] data, input logic last);
    int b = 0;
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && b < 50) begin
      @(negedge clock);
      b++;
    end
    if (!in_ready) check("send_timeout", 320'(in_ready), 320'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_vec(input int idx);
    logic [N*W-1:0] exp = '0;
    vec_t v = vecs[idx];
    for (int i = 0; i < N; i++) exp[i*W +: W] = (i < v.n) ? v.w[i] : '0;
    for (int i = 0; i < v.n; i++) begin
      send(v.w[i], (v.n < N) && (i == v.n - 1));
      check($sformatf("v%0d_count_w%0d", idx, i), 320'(fill_count), 320'(i + 1));
      check($sformatf("v%0d_valid_w%0d", idx, i), 320'(addends_valid), 320'(i == v.n - 1));
    end
    check($sformatf("v%0d_addends", idx), 320'(addends), 320'(exp));
    check($sformatf("v%0d_sum", idx), 320'(vsum(addends)), 320'(v.sum));
    @(posedge clock);
    #1;
    check($sformatf("v%0d_drain_valid", idx), 320'(addends_valid), 320'(0));
    check($sformatf("v%0d_drain_count", idx), 320'(fill_count), 320'(0));
    check($sformatf("v%0d_drain_addends", idx), 320'(addends), 320'(0));
  endtask

  initial begin
    logic [N*W-1:0] exp;

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) vecs[k].w[i] = '0;
    end
    vecs[0].n = 8;
    for (int i = 0; i < N; i++) vecs[0].w[i] = W'(i + 1);
    vecs[0].sum = 40'd36;
    vecs[1].n = 3;
    vecs[1].w[0] = 36'd5; vecs[1].w[1] = 36'd7; vecs[1].w[2] = 36'd9;
    vecs[1].sum = 40'd21;
    vecs[2].n = 1;
    vecs[2].w[0] = MaxWord;
    vecs[2].sum = 40'h0F_FFFF_FFFF;
    vecs[3].n = 8;
    vecs[3].w[7] = MaxWord;
    vecs[3].sum = 40'h0F_FFFF_FFFF;
    vecs[4].n = 5;
    vecs[4].w[0] = 36'h5_5555_5555; vecs[4].w[1] = 36'hA_AAAA_AAAA;
    vecs[4].w[2] = 36'd1;           vecs[4].w[3] = 36'd2;
    vecs[4].w[4] = 36'h8_0000_0000;
    vecs[4].sum = 40'h18_0000_0002;

    #1;
    check("reset_valid", 320'(addends_valid), 320'(0));
    check("reset_count", 320'(fill_count), 320'(0));
    check("reset_addends", 320'(addends), 320'(0));
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 320'(in_ready), 320'(1));

    // in_data/in_last are ignored while in_valid is low.
    in_data = 36'h123; in_last = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_count", 320'(fill_count), 320'(0));
    check("idle_valid", 320'(addends_valid), 320'(0));
    in_last = 1'b0;

    // Asynchronous reset mid-group discards the partial vector.
    send(36'd11, 1'b0); send(36'd12, 1'b0); send(36'd13, 1'b0);
    @(negedge clock);
    check("partial_count", 320'(fill_count), 320'(3));
    #2 reset = 1'b1;
    #1;
    check("async_reset_count", 320'(fill_count), 320'(0));
    check("async_reset_addends", 320'(addends), 320'(0));
    check("async_reset_valid", 320'(addends_valid), 320'(0));
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 5; k++) apply_vec(k);

    // Backpressure: full vector of ones held while downstream stalls.
    addends_ready = 1'b0;
    for (int i = 0; i < N; i++) send(36'd1, 1'b0);
    exp = '0;
    for (int i = 0; i < N; i++) exp[i*W +: W] = 36'd1;
    in_data = 36'd99; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check($sformatf("bp_in_ready_c%0d", c), 320'(in_ready), 320'(0));
      check($sformatf("bp_addends_c%0d", c), 320'(addends), 320'(exp));
      check($sformatf("bp_count_c%0d", c), 320'(fill_count), 320'(8));
    end
    check("bp_sum", 320'(vsum(addends)), 320'(8));
    addends_ready = 1'b1;
    #1;
    check("bp_ready_passthru", 320'(in_ready), 320'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    // Simultaneous handoff with a last word: one-word vector, stays full.
    check("handoff_valid", 320'(addends_valid), 320'(1));
    check("handoff_count", 320'(fill_count), 320'(1));
    check("handoff_addends", 320'(addends), 320'(99));
    @(posedge clock);
    #1;
    check("handoff_drain_valid", 320'(addends_valid), 320'(0));

    // Back-to-back groups 0..15 with no bubble on in_ready.
    exp = '0;
    for (int i = 0; i < N; i++) exp[i*W +: W] = W'(i);
    for (int k = 0; k < 16; k++) begin
      in_data = W'(k); in_last = 1'b0; in_valid = 1'b1;
      @(negedge clock);
      check($sformatf("b2b_in_ready_k%0d", k), 320'(in_ready), 320'(1));
      if (k == 8) begin
        check("b2b_v0_valid", 320'(addends_valid), 320'(1));
        check("b2b_v0_addends", 320'(addends), 320'(exp));
        check("b2b_v0_sum", 320'(vsum(addends)), 320'(28));
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) exp[i*W +: W] = W'(i + 8);
    check("b2b_v1_valid", 320'(addends_valid), 320'(1));
    check("b2b_v1_count", 320'(fill_count), 320'(8));
    check("b2b_v1_addends", 320'(addends), 320'(exp));
    check("b2b_v1_sum", 320'(vsum(addends)), 320'(92));
    @(posedge clock);
    #1;
    check("b2b_drain_valid", 320'(addends_valid), 320'(0));
    check("b2b_drain_count", 320'(fill_count), 320'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
